// File: rtl/ame_solver_sched.sv
// rtl/ame_solver_sched.sv - round-robin scheduler sharing one affine equation solver
//
// Shares a single non-pipelined Gaussian-elimination solver between REQ_NUM
// requesters. One problem is in flight at a time:
//   IDLE -> LAUNCH -> WAIT -> RESP -> IDLE
//
// Optional feature: define AME_SCHED_TIMEOUT_EN to enable a WAIT watchdog
// (TIMEOUT_CYCLES). When it fires, the result is returned with rsp_err_o = 1
// and zero data. Without the macro, WAIT has no limit and rsp_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   req_valid_i      per-requester request pending
//   req_ready_o      one-hot accept pulse (combinational, IDLE only)
//   req_param6_i     per-requester 6-param (1) / 4-param (0) mode
//   req_tag_i        requester i tag at [i*TAG_BITS +: TAG_BITS]
//   req_data_i       requester i matrix at [i*42*W +: 42*W],
//                    word (row r, col c) at [(r*7+c)*W +: W]
//   rsp_valid_o      one-hot result valid toward the originating requester
//   rsp_ready_i      result consumed (only the granted bit is honoured)
//   rsp_tag_o        echoed request tag
//   rsp_err_o        result invalid (watchdog expiry)
//   rsp_data_o       X0..X5, Xk at [k*W +: W]
//   slv_init_o       solver start pulse
//   slv_param6_o     solver mode
//   slv_data_o       registered solver matrix (same layout as one req_data_i slot)
//   slv_done_i       solver done pulse
//   slv_data_i       solver results (same layout as rsp_data_o)
//   busy_o           high whenever the FSM is not in IDLE

module ame_solver_sched #(
    parameter int REQ_NUM        = 4,
    parameter int REQ_IDX_BITS   = 2,
    parameter int COMP_DATA_BITS = 64,
    parameter int TAG_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [REQ_NUM-1:0]                    req_valid_i,
    output logic [REQ_NUM-1:0]                    req_ready_o,
    input  logic [REQ_NUM-1:0]                    req_param6_i,
    input  logic [REQ_NUM*TAG_BITS-1:0]           req_tag_i,
    input  logic [REQ_NUM*42*COMP_DATA_BITS-1:0]  req_data_i,
    output logic [REQ_NUM-1:0]                    rsp_valid_o,
    input  logic [REQ_NUM-1:0]                    rsp_ready_i,
    output logic [TAG_BITS-1:0]                   rsp_tag_o,
    output logic                                  rsp_err_o,
    output logic [6*COMP_DATA_BITS-1:0]           rsp_data_o,
    output logic                                  slv_init_o,
    output logic                                  slv_param6_o,
    output logic [42*COMP_DATA_BITS-1:0]          slv_data_o,
    input  logic                                  slv_done_i,
    input  logic [6*COMP_DATA_BITS-1:0]           slv_data_i,
    output logic                                  busy_o
);

    localparam int MAT_BITS = 42 * COMP_DATA_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state;
    logic [REQ_IDX_BITS-1:0] ptr;
    logic [REQ_IDX_BITS-1:0] cur_idx;
    logic [TAG_BITS-1:0]     cur_tag;

    logic                    gnt_found;
    logic [REQ_IDX_BITS-1:0] gnt_idx;

    logic [MAT_BITS-1:0]     req_mat [REQ_NUM];
    logic [TAG_BITS-1:0]     req_tag [REQ_NUM];

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_unpack
        assign req_mat[i] = req_data_i[i*MAT_BITS +: MAT_BITS];
        assign req_tag[i] = req_tag_i[i*TAG_BITS +: TAG_BITS];
    end

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = int'(ptr) + i;
            if (cand >= REQ_NUM) begin
                cand = cand - REQ_NUM;
            end
            if (!gnt_found && req_valid_i[REQ_IDX_BITS'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = REQ_IDX_BITS'(cand);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

`ifdef AME_SCHED_TIMEOUT_EN
    localparam int TO_BITS = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    logic [TO_BITS-1:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign rsp_err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            ptr          <= '0;
            cur_idx      <= '0;
            cur_tag      <= '0;
            slv_init_o   <= 1'b0;
            slv_param6_o <= 1'b0;
            slv_data_o   <= '0;
            rsp_valid_o  <= '0;
            rsp_tag_o    <= '0;
            rsp_data_o   <= '0;
            busy_o       <= 1'b0;
`ifdef AME_SCHED_TIMEOUT_EN
            rsp_err_o    <= 1'b0;
            to_cnt       <= '0;
`endif
        end else begin
            slv_init_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        cur_idx      <= gnt_idx;
                        cur_tag      <= req_tag[gnt_idx];
                        slv_data_o   <= req_mat[gnt_idx];
                        slv_param6_o <= req_param6_i[gnt_idx];
                        ptr          <= (gnt_idx == REQ_IDX_BITS'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
                        slv_init_o   <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A done arriving here belongs to no problem of ours and is dropped.
`ifdef AME_SCHED_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (slv_done_i) begin
                        rsp_data_o  <= slv_data_i;
                        rsp_tag_o   <= cur_tag;
                        rsp_valid_o <= {{(REQ_NUM-1){1'b0}}, 1'b1} << cur_idx;
`ifdef AME_SCHED_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef AME_SCHED_TIMEOUT_EN
                    else if (to_cnt == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_o  <= '0;
                        rsp_tag_o   <= cur_tag;
                        rsp_valid_o <= {{(REQ_NUM-1){1'b0}}, 1'b1} << cur_idx;
                        rsp_err_o   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // Only the originating requester can retire the result.
                    if (rsp_ready_i[cur_idx]) begin
                        rsp_valid_o <= '0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
